// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes instruction-fetch and data accesses onto one
// fixed-latency, single-ported memory. Data wins ties unless fetch has been
// passed over MAX_STREAK times in a row. Each access runs IDLE -> CMD -> WAIT
// -> DONE with one mReq strobe and a one-cycle ready pulse for its owner.
//
// Handshake: iReq/dReq are levels that the requester holds until its ready
// pulse. Ready is a single-cycle pulse in the DONE state. Read data is
// registered and stays put until the next completion of the same kind.
// Dropping a request mid-access does not cancel the access.
module mem_port_arbiter #(
    parameter int LAT        = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        iReq,
    input  logic [63:0] iAddr,
    output logic        iReady,
    output logic [63:0] iRData,
    input  logic        dReq,
    input  logic        dWe,
    input  logic [63:0] dAddr,
    input  logic [63:0] dWData,
    output logic        dReady,
    output logic [63:0] dRData,
    output logic        stallIF,
    output logic        stallMEM,
    output logic        mReq,
    output logic        mWe,
    output logic [63:0] mAddr,
    output logic [63:0] mWData,
    input  logic [63:0] mRData,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LAT);
    localparam logic [3:0] MAX_C = 4'(MAX_STREAK);

    state_t      state_q;
    logic        grant_data_q;
    logic        acc_we_q;
    logic [3:0]  streak_q;
    logic [3:0]  cnt_q;
    logic        mReq_q;
    logic        mWe_q;
    logic [63:0] mAddr_q;
    logic [63:0] mWData_q;
    logic [63:0] iRData_q;
    logic [63:0] dRData_q;
    logic        iReady_q;
    logic        dReady_q;

    logic        grant_data_d;
    logic        grant_fetch_d;
    logic [3:0]  streak_d;

    // Arbitration decision for the IDLE state and the streak update it implies.
    always_comb begin
        grant_data_d  = dReq && (!iReq || (streak_q < MAX_C));
        grant_fetch_d = !grant_data_d && iReq;
        streak_d      = streak_q;
        if (grant_data_d) begin
            if (iReq) begin
                streak_d = (streak_q >= MAX_C) ? MAX_C : streak_q + 4'd1;
            end else begin
                streak_d = 4'd0;
            end
        end else if (grant_fetch_d) begin
            streak_d = 4'd0;
        end
    end

    // Access sequencer with registered memory command and ready/data outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            grant_data_q <= 1'b0;
            acc_we_q     <= 1'b0;
            streak_q     <= 4'd0;
            cnt_q        <= 4'd0;
            mReq_q       <= 1'b0;
            mWe_q        <= 1'b0;
            mAddr_q      <= 64'd0;
            mWData_q     <= 64'd0;
            iRData_q     <= 64'd0;
            dRData_q     <= 64'd0;
            iReady_q     <= 1'b0;
            dReady_q     <= 1'b0;
        end else begin
            iReady_q <= 1'b0;
            dReady_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_data_d || grant_fetch_d) begin
                        state_q      <= S_CMD;
                        grant_data_q <= grant_data_d;
                        acc_we_q     <= grant_data_d && dWe;
                        streak_q     <= streak_d;
                        mReq_q       <= 1'b1;
                        mWe_q        <= grant_data_d && dWe;
                        mAddr_q      <= grant_data_d ? dAddr : iAddr;
                        mWData_q     <= grant_data_d ? dWData : 64'd0;
                    end
                end
                S_CMD: begin
                    // The strobe and write enable live for exactly this cycle.
                    mReq_q  <= 1'b0;
                    mWe_q   <= 1'b0;
                    cnt_q   <= LAT_C;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        if (!grant_data_q) begin
                            iRData_q <= mRData;
                        end else if (!acc_we_q) begin
                            dRData_q <= mRData;
                        end
                        iReady_q <= !grant_data_q;
                        dReady_q <= grant_data_q;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign iReady   = iReady_q;
    assign dReady   = dReady_q;
    assign iRData   = iRData_q;
    assign dRData   = dRData_q;
    assign mReq     = mReq_q;
    assign mWe      = mWe_q;
    assign mAddr    = mAddr_q;
    assign mWData   = mWData_q;
    assign stallIF  = iReq & ~iReady_q;
    assign stallMEM = dReq & ~dReady_q;
    assign dbgState = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int MAX_STREAK = 4;

    // Clock / reset
    logic        Clk = 1'b0;
    logic        Rst;
    always #5 Clk = ~Clk;

    logic        iReq, dReq, dWe;
    logic [63:0] iAddr, dAddr, dWData;
    logic        iReady, dReady, stallIF, stallMEM, mReq, mWe;
    logic [63:0] iRData, dRData, mAddr, mWData;
    logic [63:0] mRData = 64'd0;
    logic [1:0]  dbgState;

    mem_port_arbiter #(.LAT(LAT), .MAX_STREAK(MAX_STREAK)) dut (
        .Clk(Clk), .Rst(Rst),
        .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .iRData(iRData),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData),
        .dReady(dReady), .dRData(dRData),
        .stallIF(stallIF), .stallMEM(stallMEM),
        .mReq(mReq), .mWe(mWe), .mAddr(mAddr), .mWData(mWData),
        .mRData(mRData), .dbgState(dbgState)
    );

    // Memory model: read data is valid only during the cycle LAT after mReq.
    logic [63:0] mem [logic [63:0]];
    int          rd_cnt = 0;
    logic [63:0] rd_data = 64'd0;
    always @(posedge Clk) begin
        if (mReq && mWe) mem[mAddr] = mWData;
        if (mReq && !mWe) begin
            rd_cnt  = LAT;
            rd_data = mem.exists(mAddr) ? mem[mAddr] : 64'd0;
        end else if (rd_cnt > 0) begin
            rd_cnt--;
        end
        mRData <= (rd_cnt == 1) ? rd_data : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Command log
    int          cyc = 0;
    logic [63:0] log_addr[$];
    int          log_cyc[$];
    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) begin
        if (mReq) begin
            log_addr.push_back(mAddr);
            log_cyc.push_back(cyc);
        end
    end

    // Scoreboard
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] acc;
        int nd, ni, k;
        logic seen;

        Rst = 1'b1; iReq = 0; dReq = 0; dWe = 0;
        iAddr = '0; dAddr = '0; dWData = '0;
        mem[64'h40] = 64'h0000_0000_9100_0421;

        // Reset / idle
        acc = '0;
        repeat (5) begin
            @(negedge Clk);
            acc = acc | {58'd0, mReq, mWe, iReady, dReady, stallIF, stallMEM};
            acc = acc | mAddr | mWData | iRData | dRData | {62'd0, dbgState};
        end
        check("reset_outputs", acc, 64'd0);
        Rst = 1'b0;
        acc = '0;
        repeat (8) begin
            @(negedge Clk);
            acc = acc | {58'd0, mReq, mWe, iReady, dReady, stallIF, stallMEM};
            acc = acc | mAddr | mWData | iRData | dRData | {62'd0, dbgState};
        end
        check("idle_outputs", acc, 64'd0);

        // Fetch read
        iReq = 1; iAddr = 64'h40;
        tick(1);
        check("f_mreq_c1", {63'd0, mReq}, 64'd1);
        check("f_maddr", mAddr, 64'h40);
        check("f_mwe", {63'd0, mWe}, 64'd0);
        check("f_stallif_busy", {63'd0, stallIF}, 64'd1);
        tick(1);
        check("f_mreq_c2", {63'd0, mReq}, 64'd0);
        check("f_state_wait", {62'd0, dbgState}, 64'd2);
        tick(1);
        check("f_iready_c3", {63'd0, iReady}, 64'd0);
        tick(1);
        check("f_iready_c4", {63'd0, iReady}, 64'd1);
        check("f_irdata", iRData, 64'h0000_0000_9100_0421);
        check("f_stallif_done", {63'd0, stallIF}, 64'd0);
        iReq = 0;
        tick(1);
        check("f_iready_c5", {63'd0, iReady}, 64'd0);
        check("f_state_idle", {62'd0, dbgState}, 64'd0);

        // Data write then read
        dReq = 1; dWe = 1; dAddr = 64'h80; dWData = 64'h1234_5678_9ABC_DEF0;
        tick(1);
        check("w_mreq", {63'd0, mReq}, 64'd1);
        check("w_mwe_c1", {63'd0, mWe}, 64'd1);
        check("w_mwdata", mWData, 64'h1234_5678_9ABC_DEF0);
        tick(1);
        check("w_mwe_c2", {63'd0, mWe}, 64'd0);
        check("w_maddr_held", mAddr, 64'h80);
        tick(1);
        check("w_stallmem", {63'd0, stallMEM}, 64'd1);
        tick(1);
        check("w_dready", {63'd0, dReady}, 64'd1);
        check("w_drdata_kept", dRData, 64'd0);
        check("w_stallmem_done", {63'd0, stallMEM}, 64'd0);
        dReq = 0; dWe = 0;
        tick(1);
        dReq = 1; dWe = 0; dAddr = 64'h80;
        tick(1);
        check("r_mwe", {63'd0, mWe}, 64'd0);
        tick(3);
        check("r_dready", {63'd0, dReady}, 64'd1);
        check("r_drdata", dRData, 64'h1234_5678_9ABC_DEF0);
        dReq = 0;
        tick(1);

        // Conflict: data first, fetch 5 cycles later
        log_addr.delete(); log_cyc.delete();
        iReq = 1; iAddr = 64'h40; dReq = 1; dAddr = 64'h80; dWe = 0;
        seen = 0;
        for (k = 0; k < 40 && !seen; k++) begin
            @(negedge Clk);
            if (dReady) dReq = 0;
            if (iReady) begin iReq = 0; seen = 1; end
        end
        check("c_done", {63'd0, seen}, 64'd1);
        check("c_count", 64'(log_addr.size()), 64'd2);
        check("c_first", log_addr[0], 64'h80);
        check("c_second", log_addr[1], 64'h40);
        check("c_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd5);
        check("c_irdata", iRData, 64'h0000_0000_9100_0421);
        tick(1);

        // Starvation limit: D,D,D,D,I,D
        log_addr.delete(); log_cyc.delete();
        exp_q = {64'h100, 64'h100, 64'h100, 64'h100, 64'h40, 64'h100};
        iReq = 1; iAddr = 64'h40; dReq = 1; dAddr = 64'h100; dWe = 0;
        nd = 0; ni = 0;
        for (k = 0; k < 200 && !(nd == 5 && ni == 1); k++) begin
            @(negedge Clk);
            if (dReady) begin nd++; if (nd == 5) dReq = 0; end
            if (iReady) begin ni++; iReq = 0; end
        end
        check("s_data_done", 64'(nd), 64'd5);
        check("s_fetch_done", 64'(ni), 64'd1);
        check("s_count", 64'(log_addr.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("s_order%0d", i), log_addr[i], exp_q[i]);
        end
        tick(1);

        // Reset mid-access
        dReq = 1; dAddr = 64'h80; dWe = 0;
        tick(2);
        check("x_state_wait", {62'd0, dbgState}, 64'd2);
        Rst = 1; dReq = 0;
        tick(1);
        check("x_state_idle", {62'd0, dbgState}, 64'd0);
        check("x_drdata_reset", dRData, 64'd0);
        Rst = 0;
        seen = 0;
        repeat (6) begin
            @(negedge Clk);
            seen = seen | dReady | iReady | mReq;
        end
        check("x_no_activity", {63'd0, seen}, 64'd0);
        check("x_drdata_ignored", dRData, 64'd0);
        dReq = 1; dAddr = 64'h80; dWe = 0;
        tick(4);
        check("x_dready", {63'd0, dReady}, 64'd1);
        check("x_drdata", dRData, 64'h1234_5678_9ABC_DEF0);
        dReq = 0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
